imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the instruction and immediate width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, the input request is valid.
REQ-005 SHALL have port in_ready, output, 1, the encoder accepts the input this cycle.
REQ-006 SHALL have port in_imm, input, DATA_WIDTH, the signed immediate value to encode.
REQ-007 SHALL have port in_imm_op, input, 3, the format select from isa_shared: IMM_3120 (I)=0, S=1, B=2, U=3, J=4.
REQ-008 SHALL have port in_base, input, DATA_WIDTH, the instruction word supplying all non-immediate bits.
REQ-009 SHALL have port out_valid, output, 1, the output word is valid.
REQ-010 SHALL have port out_ready, input, 1, the consumer accepts the output.
REQ-011 SHALL have port out_instruction, output, DATA_WIDTH, the encoded instruction.
REQ-012 SHALL have port out_range_err, output, 1, the immediate was not representable; qualified by out_valid.
REQ-013 SHALL have port err_sticky, output, 1, set when any word with range error is handed off.
REQ-014 SHALL have port err_clear, input, 1, synchronous clear of err_sticky.
REQ-015 SHALL have port enc_count, output, 16, the count of output handshakes.

Function
REQ-016 SHALL accept an input when in_valid && in_ready, and SHALL hand off an output when out_valid && out_ready.
REQ-017 SHALL use two register stages: A (encode plus range check) and B (output); latency is 2 edges from accept to out_valid high.
REQ-018 SHALL set in_ready = !A_valid || !B_valid || out_ready; stage A moves to B when B is empty or draining; sustains 1 word/cycle when out_ready=1.
REQ-019 SHALL preserve order with no loss or duplication under any out_ready pattern; out_instruction/out_range_err stable while out_valid && !out_ready.
REQ-020 SHALL take bits outside the selected immediate fields from in_base; immediate-field bits of in_base are overwritten.
REQ-021 I: inst[31:20]=imm[11:0]; error unless -2048<=imm<=2047.
REQ-022 S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]; same range as I.
REQ-023 B: inst[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; error unless -4096<=imm<=4094 and imm[0]=0.
REQ-024 U: inst[31:12]=imm[31:12]; error if imm[11:0]!=0.
REQ-025 J: inst[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; error unless -2^20<=imm<=2^20-2 and imm[0]=0.
REQ-026 On range error, SHALL still emit the truncated field encoding and SHALL set out_range_err=1.
REQ-027 SHALL pass in_base unchanged for in_imm_op values 5-7, with out_range_err=1.
REQ-028 SHALL increment enc_count by 1 per output handshake, wrapping from 0xFFFF to 0.
REQ-029 SHALL set err_sticky on an error handshake; err_clear clears it; simultaneous clear and error handshake SHALL leave err_sticky=1.

Reset
REQ-030 While rst_n=0: A_valid=B_valid=0, out_valid=0, out_instruction=0, out_range_err=0, err_sticky=0, enc_count=0; in_ready=1.
REQ-031 Reset mid-operation SHALL discard in-flight words, with no output handshake after release until new inputs arrive.

Verification
REQ-032 I, base 0x00000093, imm 0xFFFFFFFF, out_ready=1 -> 2 edges later out_instruction=0xFFF00093, out_range_err=0.
REQ-033 B, base 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3; then B imm 3 -> out_range_err=1, err_sticky=1.
REQ-034 U, base 0x000000B7, imm 0x12345000 -> 0x123450B7; I, base 0x00000093, imm 2048 -> 0x80000093 with out_range_err=1.
REQ-035 out_ready=0, push 3 words -> 2 accepted, then in_ready=0; out_ready=1 -> 3 outputs in order, enc_count=3.
REQ-036 Stream 4 words back-to-back with rst_n pulsed low for one cycle after the 2nd accept -> out_valid=0, enc_count=0; later inputs encode normally.

Source files
------------

// File: rtl/imm_encoder.sv
// Two-stage RISC-V immediate encoder: merges a signed immediate into a base
// instruction word and flags immediates that the selected format cannot represent.
module imm_encoder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [2:0]            in_imm_op,
    input  logic [DATA_WIDTH-1:0] in_base,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instruction,
    output logic                  out_range_err,
    output logic                  err_sticky,
    input  logic                  err_clear,
    output logic [15:0]           enc_count
);

    localparam logic [2:0] OP_I = 3'd0;
    localparam logic [2:0] OP_S = 3'd1;
    localparam logic [2:0] OP_B = 3'd2;
    localparam logic [2:0] OP_U = 3'd3;
    localparam logic [2:0] OP_J = 3'd4;

    // Returns {range_err, instruction}; out-of-range values still get their truncated fields.
    function automatic logic [DATA_WIDTH:0] encode(
        input logic [2:0]            op,
        input logic [DATA_WIDTH-1:0] imm,
        input logic [DATA_WIDTH-1:0] base
    );
        logic [DATA_WIDTH-1:0] inst;
        logic                  err;
        inst = base;
        err  = 1'b1;
        case (op)
            OP_I: begin
                inst = {imm[11:0], base[19:0]};
                err  = (imm[31:11] != {21{imm[11]}});
            end
            OP_S: begin
                inst = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
                err  = (imm[31:11] != {21{imm[11]}});
            end
            OP_B: begin
                inst = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
                err  = (imm[31:12] != {20{imm[12]}}) || imm[0];
            end
            OP_U: begin
                inst = {imm[31:12], base[11:0]};
                err  = (imm[11:0] != 12'h000);
            end
            OP_J: begin
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
                err  = (imm[31:20] != {12{imm[20]}}) || imm[0];
            end
            default: begin
                inst = base;
                err  = 1'b1;
            end
        endcase
        return {err, inst};
    endfunction

    logic                  a_valid_r;
    logic [DATA_WIDTH-1:0] a_inst_r;
    logic                  a_err_r;
    logic                  b_valid_r;
    logic [DATA_WIDTH-1:0] b_inst_r;
    logic                  b_err_r;
    logic                  err_sticky_r;
    logic [15:0]           enc_count_r;

    logic                  accept_s;
    logic                  a_move_s;
    logic                  out_hs_s;
    logic [DATA_WIDTH:0]   enc_s;

    // Handshake qualifiers and combinational encode of the incoming request.
    always_comb begin
        in_ready = !a_valid_r || !b_valid_r || out_ready;
        accept_s = in_valid && in_ready;
        a_move_s = a_valid_r && (!b_valid_r || out_ready);
        out_hs_s = b_valid_r && out_ready;
        enc_s    = encode(in_imm_op, in_imm, in_base);
    end

    // Stage A: captures the encoded word and range flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_r <= 1'b0;
            a_inst_r  <= '0;
            a_err_r   <= 1'b0;
        end else if (accept_s) begin
            a_valid_r <= 1'b1;
            a_inst_r  <= enc_s[DATA_WIDTH-1:0];
            a_err_r   <= enc_s[DATA_WIDTH];
        end else if (a_move_s) begin
            a_valid_r <= 1'b0;
        end
    end

    // Stage B: output register, holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid_r <= 1'b0;
            b_inst_r  <= '0;
            b_err_r   <= 1'b0;
        end else if (a_move_s) begin
            b_valid_r <= 1'b1;
            b_inst_r  <= a_inst_r;
            b_err_r   <= a_err_r;
        end else if (out_hs_s) begin
            b_valid_r <= 1'b0;
        end
    end

    // Handshake counter and sticky error; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count_r  <= 16'h0000;
            err_sticky_r <= 1'b0;
        end else begin
            if (out_hs_s) begin
                enc_count_r <= enc_count_r + 16'h0001;
            end
            if (out_hs_s && b_err_r) begin
                err_sticky_r <= 1'b1;
            end else if (err_clear) begin
                err_sticky_r <= 1'b0;
            end
        end
    end

    assign out_valid       = b_valid_r;
    assign out_instruction = b_inst_r;
    assign out_range_err   = b_err_r;
    assign err_sticky      = err_sticky_r;
    assign enc_count       = enc_count_r;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: table of hand-encoded vectors plus
// backpressure, sticky-clear and mid-stream reset sequences.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_imm = 32'h0;
    logic [2:0]  in_imm_op = 3'd0;
    logic [31:0] in_base = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instruction;
    logic        out_range_err;
    logic        err_sticky;
    logic        err_clear = 1'b0;
    logic [15:0] enc_count;

    int total = 0;
    int bad = 0;
    int cnt_exp = 0;
    logic sticky_exp = 1'b0;

    imm_encoder #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_imm_op(in_imm_op), .in_base(in_base),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_range_err(out_range_err),
        .err_sticky(err_sticky), .err_clear(err_clear), .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge with out_ready=1 and an empty pipe.
    task automatic send(input vec_t v, input int idx);
        in_imm_op = v.op; in_imm = v.imm; in_base = v.base; in_valid = 1'b1;
        chk($sformatf("v%0d_in_ready", idx), {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk($sformatf("v%0d_lat1_valid", idx), {31'h0, out_valid}, 32'h0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_valid", idx), {31'h0, out_valid}, 32'h1);
        chk($sformatf("v%0d_inst", idx), out_instruction, v.inst);
        chk($sformatf("v%0d_err", idx), {31'h0, out_range_err}, {31'h0, v.err});
        @(posedge clk); #1;
        cnt_exp++;
        sticky_exp = sticky_exp | v.err;
        chk($sformatf("v%0d_count", idx), {16'h0, enc_count}, cnt_exp[31:0]);
        chk($sformatf("v%0d_sticky", idx), {31'h0, err_sticky}, {31'h0, sticky_exp});
        chk($sformatf("v%0d_drained", idx), {31'h0, out_valid}, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt_exp = 0;
        sticky_exp = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] exp_q[3];
        vec_t v;
        int got;

        vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000093, 32'hFFF00093, 1'b0};
        vecs[1]  = '{3'd2, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0};
        vecs[2]  = '{3'd2, 32'h00000003, 32'h00000063, 32'h00000163, 1'b1};
        vecs[3]  = '{3'd3, 32'h12345000, 32'h000000B7, 32'h123450B7, 1'b0};
        vecs[4]  = '{3'd0, 32'h00000800, 32'h00000093, 32'h80000093, 1'b1};
        vecs[5]  = '{3'd0, 32'h000007FF, 32'h00000093, 32'h7FF00093, 1'b0};
        vecs[6]  = '{3'd0, 32'hFFFFF800, 32'h00000093, 32'h80000093, 1'b0};
        vecs[7]  = '{3'd1, 32'hFFFFFFF8, 32'h00002023, 32'hFE002C23, 1'b0};
        vecs[8]  = '{3'd0, 32'h00000000, 32'hFFFFFFFF, 32'h000FFFFF, 1'b0};
        vecs[9]  = '{3'd2, 32'h00000FFE, 32'h00000063, 32'h7E000FE3, 1'b0};
        vecs[10] = '{3'd2, 32'h00001000, 32'h00000063, 32'h80000063, 1'b1};
        vecs[11] = '{3'd2, 32'hFFFFF000, 32'h00000063, 32'h80000063, 1'b0};
        vecs[12] = '{3'd3, 32'h00001001, 32'h000000B7, 32'h000010B7, 1'b1};
        vecs[13] = '{3'd4, 32'h00000002, 32'h0000006F, 32'h0020006F, 1'b0};
        vecs[14] = '{3'd4, 32'h000FFFFE, 32'h0000006F, 32'h7FFFF06F, 1'b0};
        vecs[15] = '{3'd4, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1};
        vecs[16] = '{3'd4, 32'hFFF00000, 32'h0000006F, 32'h8000006F, 1'b0};
        vecs[17] = '{3'd4, 32'h00000001, 32'h0000006F, 32'h0000006F, 1'b1};
        vecs[18] = '{3'd5, 32'h00000000, 32'h12345678, 32'h12345678, 1'b1};

        // Reset state
        #1;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_inst", out_instruction, 32'h0);
        chk("rst_err", {31'h0, out_range_err}, 32'h0);
        chk("rst_sticky", {31'h0, err_sticky}, 32'h0);
        chk("rst_count", {16'h0, enc_count}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) send(vecs[i], i);

        // err_clear alone clears the sticky flag
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        sticky_exp = 1'b0;
        chk("clear_sticky", {31'h0, err_sticky}, 32'h0);

        // Clear coinciding with an error handshake leaves sticky set
        in_imm_op = 3'd7; in_imm = 32'h0; in_base = 32'hDEADBEEF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("op7_inst", out_instruction, 32'hDEADBEEF);
        chk("op7_err", {31'h0, out_range_err}, 32'h1);
        err_clear = 1'b1;
        @(posedge clk); #1;
        cnt_exp++;
        chk("clear_vs_set_sticky", {31'h0, err_sticky}, 32'h1);
        chk("clear_vs_set_count", {16'h0, enc_count}, cnt_exp[31:0]);
        @(posedge clk); #1;
        err_clear = 1'b0;
        chk("clear_after_sticky", {31'h0, err_sticky}, 32'h0);

        // Backpressure: only two words fit, then drain in order
        do_reset();
        exp_q[0] = 32'h00100013; exp_q[1] = 32'h00200013; exp_q[2] = 32'h00300013;
        out_ready = 1'b0;
        in_imm_op = 3'd0; in_base = 32'h00000013; in_imm = 32'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_after_1", {31'h0, in_ready}, 32'h1);
        in_imm = 32'h2;
        @(posedge clk); #1;
        chk("bp_ready_after_2", {31'h0, in_ready}, 32'h0);
        chk("bp_hold_inst", out_instruction, exp_q[0]);
        in_imm = 32'h3;
        @(posedge clk); #1;
        chk("bp_still_blocked", {31'h0, in_ready}, 32'h0);
        chk("bp_stable_inst", out_instruction, exp_q[0]);
        chk("bp_stable_valid", {31'h0, out_valid}, 32'h1);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (out_valid) begin
                chk($sformatf("bp_out%0d", got), out_instruction, exp_q[got]);
                got++;
            end
            @(posedge clk); #1;
            if (c == 0) in_valid = 1'b0;
        end
        chk("bp_outputs_seen", got[31:0], 32'd3);
        chk("bp_count", {16'h0, enc_count}, 32'd3);
        cnt_exp = 3;

        // Reset pulse mid-stream discards in-flight words
        do_reset();
        in_imm_op = 3'd0; in_base = 32'h00000093; in_imm = 32'h5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_imm = 32'h6;
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_count", {16'h0, enc_count}, 32'h0);
        chk("mid_rst_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt_exp = 0;
        sticky_exp = 1'b0;
        got = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) got++;
            @(posedge clk); #1;
        end
        chk("post_rst_no_output", got[31:0], 32'd0);
        chk("post_rst_count", {16'h0, enc_count}, 32'h0);
        v = '{3'd0, 32'h00000007, 32'h00000093, 32'h00700093, 1'b0};
        send(v, 100);
        v = '{3'd3, 32'hABCDE000, 32'h00000037, 32'hABCDE037, 1'b0};
        send(v, 101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
